// File: rtl/seq_detector.sv
// Serial pattern detector built on a failure-function FSM whose transition table
// is generated from N/PATTERN at elaboration, with a saturating match counter.
module seq_detector #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             x,
  input  logic             en,
  input  logic             clr,
  output logic [SW-1:0]    state,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  if (N < 2 || N > 8) begin : gBadN
    $error("seq_detector: N must be in 2..8");
  end
  if (CNT_W < 1 || CNT_W > 16) begin : gBadCntW
    $error("seq_detector: CNT_W must be in 1..16");
  end

  localparam int ENTRIES = 2 ** (SW + 1);
  localparam int TBL_W   = ENTRIES * SW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Entry {s, b} holds the longest pattern prefix that is a suffix of
  // (first s pattern bits, then b); unreachable states map to 0.
  function automatic logic [TBL_W-1:0] buildTable();
    logic [TBL_W-1:0] tbl;
    int   fromS, len, best, pos;
    logic ok, strBit, patBit;
    tbl = '0;
    for (int s = 0; s <= N; s++) begin
      for (int b = 0; b < 2; b++) begin
        fromS = (s == N && OVERLAP == 0) ? 0 : s;
        len   = fromS + 1;
        best  = 0;
        for (int k = 1; k <= N; k++) begin
          if (k <= len) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) begin
              pos    = len - k + i;
              strBit = (pos == fromS) ? b[0] : 1'(PATTERN >> (N - 1 - pos));
              patBit = 1'(PATTERN >> (N - 1 - i));
              if (strBit != patBit) ok = 1'b0;
            end
            if (ok) best = k;
          end
        end
        tbl |= TBL_W'(best) << ((2 * s + b) * SW);
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = buildTable();

  logic [SW-1:0] nextTbl [ENTRIES];

  for (genvar g = 0; g < ENTRIES; g++) begin : gTbl
    assign nextTbl[g] = NEXT_TBL[g*SW +: SW];
  end

  logic [SW-1:0]    state_q, state_d;
  logic             match_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  always_comb begin
    state_d = nextTbl[{state_q, x}];
  end

  // match is registered alongside state so it never sees x combinationally.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= '0;
      match_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q <= '0;
      match_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      match_q <= (state_d == SW'(N));
      if (state_d == SW'(N)) begin
        if (count_q == CNT_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  assign state = state_q;
  assign match = match_q;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus stream; expectations are queued per edge.
module tb_seq_detector;

  logic clk, res, x, en, clr;

  logic [2:0] stateA, stateB, stateC;
  logic       matchA, matchB, matchC;
  logic [7:0] countA, countB;
  logic [1:0] countC;
  logic       ovfA, ovfB, ovfC;

  logic [12:0] obsA, obsB, obsC;
  assign obsA = {stateA, matchA, countA, ovfA};
  assign obsB = {stateB, matchB, countB, ovfB};
  assign obsC = {stateC, matchC, 6'd0, countC, ovfC};

  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dutA (
    .clk(clk), .res(res), .x(x), .en(en), .clr(clr),
    .state(stateA), .match(matchA), .count(countA), .ovf(ovfA));

  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dutB (
    .clk(clk), .res(res), .x(x), .en(en), .clr(clr),
    .state(stateB), .match(matchB), .count(countB), .ovf(ovfB));

  seq_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dutC (
    .clk(clk), .res(res), .x(x), .en(en), .clr(clr),
    .state(stateC), .match(matchC), .count(countC), .ovf(ovfC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] a, b, c;
    bit          ca, cb, cc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checkCount = 0;
  int   passCount  = 0;

  function automatic logic [12:0] pk(input int st, input int cnt, input bit ov);
    return {st[2:0], (st == 4), cnt[7:0], ov};
  endfunction

  task automatic applyStimulus(input bit xi, input bit enI, input bit clrI);
    @(negedge clk);
    x = xi; en = enI; clr = clrI;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1; x = 1'b0; en = 1'b0; clr = 1'b0;
    #1 res = 1'b0;
    #2;
    sb.push_back('{a:pk(0,0,0), b:pk(0,0,0), c:pk(0,0,0), ca:1, cb:1, cc:1, tag:"reset"});
    e = sb.pop_front();
    if (e.ca) begin checkCount++; if (obsA !== e.a) $display("[TB] FAIL %s A: got %b want %b", e.tag, obsA, e.a); else passCount++; end
    if (e.cb) begin checkCount++; if (obsB !== e.b) $display("[TB] FAIL %s B: got %b want %b", e.tag, obsB, e.b); else passCount++; end
    if (e.cc) begin checkCount++; if (obsC !== e.c) $display("[TB] FAIL %s C: got %b want %b", e.tag, obsC, e.c); else passCount++; end
    @(negedge clk) res = 1'b1;
  endtask

  task automatic test_overlap();
    bit xs[7]  = '{1, 0, 1, 1, 0, 1, 1};
    int stA[7] = '{1, 2, 3, 4, 2, 3, 4};
    int stB[7] = '{1, 2, 3, 4, 0, 1, 1};
    int cA = 0, cB = 0;
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      if (stA[i] == 4) cA++;
      if (stB[i] == 4) cB++;
      sb.push_back('{a:pk(stA[i],cA,0), b:pk(stB[i],cB,0), c:'0, ca:1, cb:1, cc:0, tag:$sformatf("overlap%0d", i)});
      applyStimulus(xs[i], 1, 0);
      e = sb.pop_front();
      if (e.ca) begin checkCount++; if (obsA !== e.a) $display("[TB] FAIL %s A: got %b want %b", e.tag, obsA, e.a); else passCount++; end
      if (e.cb) begin checkCount++; if (obsB !== e.b) $display("[TB] FAIL %s B: got %b want %b", e.tag, obsB, e.b); else passCount++; end
    end
  endtask

  task automatic test_hold();
    bit xs[9]  = '{1, 0, 1, 1, 0, 1, 0, 1, 1};
    bit ens[9] = '{1, 1, 1, 0, 0, 0, 0, 0, 1};
    int st[9]  = '{1, 2, 3, 3, 3, 3, 3, 3, 4};
    int cnt = 0;
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      if (ens[i] && st[i] == 4) cnt++;
      sb.push_back('{a:pk(st[i],cnt,0), b:pk(st[i],cnt,0), c:'0, ca:1, cb:1, cc:0, tag:$sformatf("hold%0d", i)});
      applyStimulus(xs[i], ens[i], 0);
      e = sb.pop_front();
      if (e.ca) begin checkCount++; if (obsA !== e.a) $display("[TB] FAIL %s A: got %b want %b", e.tag, obsA, e.a); else passCount++; end
      if (e.cb) begin checkCount++; if (obsB !== e.b) $display("[TB] FAIL %s B: got %b want %b", e.tag, obsB, e.b); else passCount++; end
    end
  endtask

  task automatic test_saturate();
    bit xs[14] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
    int st[14] = '{1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 2, 3, 4, 2};
    int cA = 0, cC = 0;
    bit oC = 0;
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 14; i++) begin
      if (st[i] == 4) begin
        cA++;
        if (cC == 3) oC = 1; else cC++;
      end
      sb.push_back('{a:pk(st[i],cA,0), b:'0, c:pk(st[i],cC,oC), ca:1, cb:0, cc:1, tag:$sformatf("sat%0d", i)});
      applyStimulus(xs[i], 1, 0);
      e = sb.pop_front();
      if (e.ca) begin checkCount++; if (obsA !== e.a) $display("[TB] FAIL %s A: got %b want %b", e.tag, obsA, e.a); else passCount++; end
      if (e.cc) begin checkCount++; if (obsC !== e.c) $display("[TB] FAIL %s C: got %b want %b", e.tag, obsC, e.c); else passCount++; end
    end
  endtask

  task automatic test_clear();
    bit xs[6]  = '{1, 1, 0, 1, 1, 0};
    bit clrs[6] = '{1, 0, 0, 0, 1, 0};
    int st[6]  = '{0, 1, 2, 3, 0, 0};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{a:pk(st[i],0,0), b:pk(st[i],0,0), c:pk(st[i],0,0), ca:1, cb:1, cc:1, tag:$sformatf("clear%0d", i)});
      applyStimulus(xs[i], 1, clrs[i]);
      e = sb.pop_front();
      if (e.ca) begin checkCount++; if (obsA !== e.a) $display("[TB] FAIL %s A: got %b want %b", e.tag, obsA, e.a); else passCount++; end
      if (e.cb) begin checkCount++; if (obsB !== e.b) $display("[TB] FAIL %s B: got %b want %b", e.tag, obsB, e.b); else passCount++; end
      if (e.cc) begin checkCount++; if (obsC !== e.c) $display("[TB] FAIL %s C: got %b want %b", e.tag, obsC, e.c); else passCount++; end
    end
  endtask

  task automatic test_async_reset();
    bit xs[10] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    int stA[10] = '{1, 2, 3, 4, 2, 3, 1, 2, 3, 4};
    int stB[10] = '{1, 2, 3, 4, 0, 1, 1, 2, 3, 4};
    int cA = 0, cB = 0;
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 6) begin
        #1 res = 1'b0;
        #1;
        cA = 0; cB = 0;
        sb.push_back('{a:pk(0,0,0), b:pk(0,0,0), c:pk(0,0,0), ca:1, cb:1, cc:1, tag:"asyncReset"});
        e = sb.pop_front();
        if (e.ca) begin checkCount++; if (obsA !== e.a) $display("[TB] FAIL %s A: got %b want %b", e.tag, obsA, e.a); else passCount++; end
        if (e.cb) begin checkCount++; if (obsB !== e.b) $display("[TB] FAIL %s B: got %b want %b", e.tag, obsB, e.b); else passCount++; end
        if (e.cc) begin checkCount++; if (obsC !== e.c) $display("[TB] FAIL %s C: got %b want %b", e.tag, obsC, e.c); else passCount++; end
        @(negedge clk) res = 1'b1;
      end
      if (stA[i] == 4) cA++;
      if (stB[i] == 4) cB++;
      sb.push_back('{a:pk(stA[i],cA,0), b:pk(stB[i],cB,0), c:pk(stA[i],cA,0), ca:1, cb:1, cc:1, tag:$sformatf("arst%0d", i)});
      applyStimulus(xs[i], 1, 0);
      e = sb.pop_front();
      if (e.ca) begin checkCount++; if (obsA !== e.a) $display("[TB] FAIL %s A: got %b want %b", e.tag, obsA, e.a); else passCount++; end
      if (e.cb) begin checkCount++; if (obsB !== e.b) $display("[TB] FAIL %s B: got %b want %b", e.tag, obsB, e.b); else passCount++; end
      if (e.cc) begin checkCount++; if (obsC !== e.c) $display("[TB] FAIL %s C: got %b want %b", e.tag, obsC, e.c); else passCount++; end
    end
  endtask

  // Reference model: longest pattern prefix that ends the bit history.
  function automatic int longestPrefix(input int hist[$]);
    int patArr[4] = '{1, 0, 1, 1};
    int best = 0;
    bit ok;
    for (int k = 1; k <= 4; k++) begin
      if (k <= hist.size()) begin
        ok = 1;
        for (int i = 0; i < k; i++)
          if (hist[hist.size() - k + i] != patArr[i]) ok = 0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic test_random();
    int hA[$], hB[$];
    int sA = 0, sB = 0, cA = 0, cB = 0;
    bit xi, enI, clrI;
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      xi   = 1'($urandom_range(0, 1));
      enI  = ($urandom_range(0, 3) != 0);
      clrI = ($urandom_range(0, 19) == 0);
      if (clrI) begin
        hA.delete(); hB.delete(); sA = 0; sB = 0; cA = 0; cB = 0;
      end else if (enI) begin
        if (sB == 4) hB.delete();
        hA.push_back(int'(xi)); hB.push_back(int'(xi));
        if (hA.size() > 8) void'(hA.pop_front());
        if (hB.size() > 8) void'(hB.pop_front());
        sA = longestPrefix(hA);
        sB = longestPrefix(hB);
        if (sA == 4) cA++;
        if (sB == 4) cB++;
      end
      sb.push_back('{a:pk(sA,cA,0), b:pk(sB,cB,0), c:'0, ca:1, cb:1, cc:0, tag:$sformatf("rand%0d", i)});
      applyStimulus(xi, enI, clrI);
      e = sb.pop_front();
      if (e.ca) begin checkCount++; if (obsA !== e.a) $display("[TB] FAIL %s A: got %b want %b", e.tag, obsA, e.a); else passCount++; end
      if (e.cb) begin checkCount++; if (obsB !== e.b) $display("[TB] FAIL %s B: got %b want %b", e.tag, obsB, e.b); else passCount++; end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_overlap();
    test_hold();
    test_saturate();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
